avst_pkt_rx_router: RTL and testbench
=====================================

AVST_PKT_RX_ROUTER -- requirements
Module: avst_pkt_rx_router

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of AVST input channels (1..4).
REQ-002 SHALL have parameter BUF_SIZE, default 16, beat buffer depth (power of two, >= 2*READY_LATENCY*NUM_CH+NUM_CH).
REQ-003 SHALL have parameter READY_LATENCY, default 3, cycles between ready deassertion and the last accepted beat.
REQ-004 SHALL have port clk, input, 1, sole clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port i_tx_st, input, t_avst_pcie_tx[NUM_CH], beats (valid/sop/eop/hdr/data), one per channel per cycle.
REQ-007 SHALL have port o_tx_st_ready, output, 1, upstream ready.
REQ-008 SHALL have port o_cpl_st, output, t_avst_pcie_tx, completion beats.
REQ-009 SHALL have port i_cpl_st_ready, input, 1, completion sink ready.
REQ-010 SHALL have port o_mem_st, output, t_avst_pcie_tx, non-completion beats.
REQ-011 SHALL have port i_mem_st_ready, input, 1, memory sink ready.
REQ-012 SHALL have port o_err, output, 2, sticky errors: [0] overflow, [1] orphan beat.

Function
REQ-013 SHALL write all valid beats of a cycle in one edge, packed contiguously from wptr in ascending channel order, skipping invalid channels.
REQ-014 SHALL drive o_tx_st_ready = (usedw < BUF_SIZE - READY_LATENCY*NUM_CH).
REQ-015 SHALL, when free entries < valid-beat count, drop every beat of that cycle and set o_err[0]; no partial write.
REQ-016 SHALL read at most one beat per cycle into a dout stage when buffer non-empty and dout is empty or consumed.
REQ-017 SHALL update usedw as usedw + writes - read in one cycle; pointers wrap modulo BUF_SIZE.
REQ-018 SHALL classify on the sop beat: hdr.dw0.fmttype[4:0]==5'b01010 routes to cpl, else mem; non-sop beats follow the latched destination.
REQ-019 SHALL stall dout only on its own destination: the destination register must be empty or its ready high (no cross-blocking by the other port).
REQ-020 SHALL hold each output valid and payload stable until its ready is sampled high.
REQ-021 SHALL have a minimum latency of 2 cycles: beat accepted at edge N is visible on its output after edge N+2.
REQ-022 SHALL discard a non-sop beat arriving at dout with no open packet and set o_err[1].
REQ-023 SHALL support a simultaneous write and read at full or empty boundaries without loss or duplication.

Reset
REQ-024 SHALL clear wptr, rptr, usedw, dout valid, the open-packet flag, o_err, and both output registers (all fields 0) while rst is high.
REQ-025 SHALL discard buffered beats and any partially delivered packet on reset mid-operation; o_tx_st_ready SHALL be 1 in the first cycle after rst falls.

Configuration
REQ-026 SHALL, with PKT_RX_STATS_EN defined, provide outputs o_cpl_pkt_cnt and o_mem_pkt_cnt (32-bit, saturating, +1 per eop delivered, cleared by rst).
REQ-027 SHALL, without PKT_RX_STATS_EN, omit the counters and their ports entirely, all other behaviour identical.

Structure
REQ-028 SHALL take t_avst_pcie_tx, NUM_AVST_CH and the completion fmttype constant from the shared PCIe package; the error-bit index constants SHALL be added there.
REQ-029 SHALL implement the buffer as sub-module pkt_rx_mwr_fifo (multi-write, single-read, usedw output).

Verification
REQ-030 SHALL cover: NUM_CH=2, 1-beat MRd on CH0 and 1-beat CplD on CH1 same cycle -> MRd on o_mem_st at N+2, CplD on o_cpl_st at N+3.
REQ-031 SHALL cover: i_mem_st_ready=0, a mem then a cpl packet -> cpl delivered; mem held stable and sent once ready=1.
REQ-032 SHALL cover: both sinks stalled, continuous 2-beat/cycle input -> ready drops at usedw=10 (BUF_SIZE 16); no loss; o_err=0.
REQ-033 SHALL cover: forcing valid while ready=0 until full -> overflowing cycle dropped entirely; o_err[0]=1 until rst.
REQ-034 SHALL cover: eop-only beat with no prior sop -> not output; o_err[1]=1.
REQ-035 SHALL cover: rst asserted mid-packet of a 4-beat write -> outputs invalid next cycle; a following packet routes correctly; counters (if PKT_RX_STATS_EN) = 0 then 1.

Source files
------------

// File: rtl/avst_pkt_rx_router_pkg.sv
// Shared PCIe AVST beat types, channel count and TLP constants used by the
// packet RX router and its beat buffer.
package avst_pkt_rx_router_pkg;

   localparam int NUM_AVST_CH = 4;

   // fmttype[4:0] of any completion TLP (Cpl, CplD; with or without data)
   localparam logic [4:0] FMTTYPE_CPL = 5'b01010;

   localparam int ERR_OVERFLOW = 0;
   localparam int ERR_ORPHAN   = 1;

   typedef struct packed {
      logic [7:0]  fmttype;
      logic [7:0]  attr;
      logic [15:0] length;
   } t_tlp_dw0;

   typedef struct packed {
      t_tlp_dw0    dw0;
      logic [31:0] dw1;
   } t_tlp_hdr;

   typedef struct packed {
      logic        valid;
      logic        sop;
      logic        eop;
      t_tlp_hdr    hdr;
      logic [31:0] data;
   } t_avst_pcie_tx;

endpackage

// File: rtl/avst_pkt_rx_router_fifo.sv
// Multi-write, single-read beat buffer: up to NUM_CH beats written per edge,
// packed contiguously from wptr; a cycle that does not fit is dropped whole.
module pkt_rx_mwr_fifo
   import avst_pkt_rx_router_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int BUF_SIZE = 16
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  t_avst_pcie_tx             wr_beat [NUM_CH],
   input  logic                      rd,
   output t_avst_pcie_tx             rd_beat,
   output logic                      empty,
   output logic [$clog2(BUF_SIZE):0] usedw,
   output logic                      overflow
);

   localparam int AW = $clog2(BUF_SIZE);
   localparam int UW = AW + 1;

   t_avst_pcie_tx mem [BUF_SIZE];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW-1:0] waddr [NUM_CH];
   logic [UW-1:0] wcount;
   logic [UW-1:0] free;
   logic [UW-1:0] wr_n;
   logic          accept;

   always_comb begin
      wcount = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         waddr[c] = wptr + wcount[AW-1:0];
         if (wr_beat[c].valid) wcount = wcount + UW'(1);
      end
   end

   // The slot being read this edge is already free for a same-edge write.
   assign free     = UW'(BUF_SIZE) - usedw + UW'(rd);
   assign accept   = (wcount <= free);
   assign wr_n     = accept ? wcount : '0;
   assign overflow = (wcount != '0) && !accept;
   assign empty    = (usedw == '0);
   assign rd_beat  = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         usedw <= '0;
      end else begin
         wptr  <= wptr + wr_n[AW-1:0];
         if (rd) rptr <= rptr + AW'(1);
         usedw <= usedw + wr_n - UW'(rd);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_beat[c].valid) mem[waddr[c]] <= wr_beat[c];
         end
      end
   end

endmodule

// File: rtl/avst_pkt_rx_router.sv
// Buffers multi-channel AVST beats and routes packets to a completion or memory
// sink by the sop header. Define PKT_RX_STATS_EN to add per-sink packet counters.
module avst_pkt_rx_router
   import avst_pkt_rx_router_pkg::*;
#(
   parameter int NUM_CH        = 2,
   parameter int BUF_SIZE      = 16,
   parameter int READY_LATENCY = 3
)
(
   input  logic          clk,
   input  logic          rst,
   input  t_avst_pcie_tx i_tx_st [NUM_CH],
   output logic          o_tx_st_ready,
   output t_avst_pcie_tx o_cpl_st,
   input  logic          i_cpl_st_ready,
   output t_avst_pcie_tx o_mem_st,
   input  logic          i_mem_st_ready,
   output logic [1:0]    o_err
`ifdef PKT_RX_STATS_EN
   ,
   output logic [31:0]   o_cpl_pkt_cnt,
   output logic [31:0]   o_mem_pkt_cnt
`endif
);

   localparam int UW           = $clog2(BUF_SIZE) + 1;
   localparam int READY_THRESH = BUF_SIZE - READY_LATENCY * NUM_CH;

   logic [UW-1:0] usedw;
   logic          fifo_empty;
   logic          fifo_ovf;
   logic          rd;
   t_avst_pcie_tx fifo_beat;
   t_avst_pcie_tx dout_beat;
   logic          dout_valid;
   logic          pkt_open;
   logic          open_dest_cpl;
   logic          dest_cpl;
   logic          orphan;
   logic          dest_free;
   logic          dout_fire;

   pkt_rx_mwr_fifo #(
      .NUM_CH   (NUM_CH),
      .BUF_SIZE (BUF_SIZE)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_beat  (i_tx_st),
      .rd       (rd),
      .rd_beat  (fifo_beat),
      .empty    (fifo_empty),
      .usedw    (usedw),
      .overflow (fifo_ovf)
   );

   // Headroom of READY_LATENCY cycles of full-width writes after ready drops.
   assign o_tx_st_ready = (usedw < UW'(READY_THRESH));

   always_comb begin
      dest_cpl = open_dest_cpl;
      orphan   = 1'b0;
      if (dout_beat.sop) dest_cpl = (dout_beat.hdr.dw0.fmttype[4:0] == FMTTYPE_CPL);
      else               orphan   = !pkt_open;
      dest_free = dest_cpl ? (!o_cpl_st.valid || i_cpl_st_ready)
                           : (!o_mem_st.valid || i_mem_st_ready);
      dout_fire = dout_valid && (orphan || dest_free);
   end

   assign rd = !fifo_empty && (!dout_valid || dout_fire);

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout_beat  <= '0;
      end else if (!dout_valid || dout_fire) begin
         dout_valid <= rd;
         if (rd) dout_beat <= fifo_beat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_open      <= 1'b0;
         open_dest_cpl <= 1'b0;
         o_err         <= '0;
      end else begin
         if (dout_fire && !orphan) begin
            pkt_open      <= !dout_beat.eop;
            open_dest_cpl <= dest_cpl;
         end
         if (fifo_ovf)            o_err[ERR_OVERFLOW] <= 1'b1;
         if (dout_fire && orphan) o_err[ERR_ORPHAN]   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_cpl_st <= '0;
      end else if (dout_fire && !orphan && dest_cpl) begin
         o_cpl_st <= dout_beat;
      end else if (i_cpl_st_ready) begin
         o_cpl_st.valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_mem_st <= '0;
      end else if (dout_fire && !orphan && !dest_cpl) begin
         o_mem_st <= dout_beat;
      end else if (i_mem_st_ready) begin
         o_mem_st.valid <= 1'b0;
      end
   end

`ifdef PKT_RX_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_cpl_pkt_cnt <= '0;
         o_mem_pkt_cnt <= '0;
      end else begin
         if (o_cpl_st.valid && i_cpl_st_ready && o_cpl_st.eop && (o_cpl_pkt_cnt != '1))
            o_cpl_pkt_cnt <= o_cpl_pkt_cnt + 32'd1;
         if (o_mem_st.valid && i_mem_st_ready && o_mem_st.eop && (o_mem_pkt_cnt != '1))
            o_mem_pkt_cnt <= o_mem_pkt_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_avst_pkt_rx_router.sv
// Self-checking bench for avst_pkt_rx_router: a packet-routing scoreboard checks
// every delivered beat, directed scenarios pin latency, flow control and errors.
module tb_avst_pkt_rx_router;
   import avst_pkt_rx_router_pkg::*;

   localparam int NUM_CH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   t_avst_pcie_tx tx [NUM_CH];
   logic          tx_ready;
   t_avst_pcie_tx cpl_st;
   t_avst_pcie_tx mem_st;
   logic          cpl_ready = 1'b1;
   logic          mem_ready = 1'b1;
   logic [1:0]    err;
`ifdef PKT_RX_STATS_EN
   logic [31:0]   cpl_cnt;
   logic [31:0]   mem_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: per-sink expected beat queues and the stream's packet framing.
   t_avst_pcie_tx cpl_q [$];
   t_avst_pcie_tx mem_q [$];
   logic          m_open;
   logic          m_dest_cpl;
   logic [1:0]    m_err;
   int            cpl_beats;
   int            mem_beats;
   int            m_cpl_pkts;
   int            m_mem_pkts;

   int            g_left = 0;
   logic          g_cpl  = 1'b0;
   int            g_tag  = 256;

   always #5 clk = ~clk;

   avst_pkt_rx_router #(
      .NUM_CH        (NUM_CH),
      .BUF_SIZE      (16),
      .READY_LATENCY (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_tx_st        (tx),
      .o_tx_st_ready  (tx_ready),
      .o_cpl_st       (cpl_st),
      .i_cpl_st_ready (cpl_ready),
      .o_mem_st       (mem_st),
      .i_mem_st_ready (mem_ready),
      .o_err          (err)
`ifdef PKT_RX_STATS_EN
      ,
      .o_cpl_pkt_cnt  (cpl_cnt),
      .o_mem_pkt_cnt  (mem_cnt)
`endif
   );

   function automatic t_avst_pcie_tx mk(input bit sop, input bit eop,
                                        input logic [7:0] ft, input logic [31:0] tag);
      t_avst_pcie_tx b;
      b                = '0;
      b.valid          = 1'b1;
      b.sop            = sop;
      b.eop            = eop;
      b.hdr.dw0.fmttype = ft;
      b.hdr.dw0.length = 16'd1;
      b.hdr.dw1        = ~tag;
      b.data           = tag;
      return b;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      cpl_q.delete();
      mem_q.delete();
      m_open     = 1'b0;
      m_dest_cpl = 1'b0;
      m_err      = 2'b00;
      cpl_beats  = 0;
      mem_beats  = 0;
      m_cpl_pkts = 0;
      m_mem_pkts = 0;
   endtask

   // Routing rules on the accepted beat stream, independent of pipeline timing.
   task automatic modelPush(input t_avst_pcie_tx b);
      if (b.sop) begin
         m_dest_cpl = (b.hdr.dw0.fmttype[4:0] == 5'b01010);
         m_open     = !b.eop;
         if (m_dest_cpl) cpl_q.push_back(b);
         else            mem_q.push_back(b);
      end else if (m_open) begin
         if (m_dest_cpl) cpl_q.push_back(b);
         else            mem_q.push_back(b);
         if (b.eop) m_open = 1'b0;
      end else begin
         m_err[1] = 1'b1;
      end
   endtask

   task automatic applyStimulus(input t_avst_pcie_tx b0, input t_avst_pcie_tx b1, input bit drop);
      tx[0] = b0;
      tx[1] = b1;
      if (drop) begin
         m_err[0] = 1'b1;
      end else begin
         if (b0.valid) modelPush(b0);
         if (b1.valid) modelPush(b1);
      end
      tick(1);
      tx[0] = '0;
      tx[1] = '0;
   endtask

   task automatic doReset();
      rst   = 1'b1;
      tx[0] = '0;
      tx[1] = '0;
      tick(2);
      modelReset();
      rst = 1'b0;
      tick(1);
   endtask

   task automatic waitDrain(input string name);
      int cycles;
      cycles    = 0;
      cpl_ready = 1'b1;
      mem_ready = 1'b1;
      while ((cpl_q.size() != 0 || mem_q.size() != 0) && cycles < 300) begin
         tick(1);
         cycles++;
      end
      tick(4);
      checkOutput({name, "_drained"}, 32'(cpl_q.size() + mem_q.size()), 32'd0);
   endtask

   task automatic nextBeat(output t_avst_pcie_tx b);
      bit sop;
      sop = (g_left == 0);
      if (sop) begin
         g_left = int'($urandom_range(1, 3));
         g_cpl  = ($urandom_range(0, 1) != 0);
      end
      b = mk(sop, g_left == 1, sop ? (g_cpl ? 8'h4A : 8'h40) : 8'h00, 32'(g_tag));
      g_tag++;
      g_left--;
   endtask

   // Every valid output beat must be the head of its sink's expected queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (cpl_st.valid) begin
            n_checks++;
            if (cpl_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL cpl_spurious: got %h expected no beat", cpl_st);
            end else begin
               if (cpl_st !== cpl_q[0]) begin
                  n_fail++;
                  $display("[TB] FAIL cpl_beat: got %h expected %h", cpl_st, cpl_q[0]);
               end
               if (cpl_ready) begin
                  if (cpl_q[0].eop) m_cpl_pkts++;
                  void'(cpl_q.pop_front());
                  cpl_beats++;
               end
            end
         end
         if (mem_st.valid) begin
            n_checks++;
            if (mem_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL mem_spurious: got %h expected no beat", mem_st);
            end else begin
               if (mem_st !== mem_q[0]) begin
                  n_fail++;
                  $display("[TB] FAIL mem_beat: got %h expected %h", mem_st, mem_q[0]);
               end
               if (mem_ready) begin
                  if (mem_q[0].eop) m_mem_pkts++;
                  void'(mem_q.pop_front());
                  mem_beats++;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      t_avst_pcie_tx b0;
      t_avst_pcie_tx b1;
      tx[0] = '0;
      tx[1] = '0;
      modelReset();
      doReset();

      // Reset state
      checkOutput("rst_cpl_valid", 32'(cpl_st.valid), 32'd0);
      checkOutput("rst_mem_valid", 32'(mem_st.valid), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_ready", 32'(tx_ready), 32'd1);

      // MRd on CH0 and CplD on CH1 in the same cycle
      applyStimulus(mk(1, 1, 8'h00, 32'h11), mk(1, 1, 8'h4A, 32'h22), 1'b0);
      tick(1);
      checkOutput("a_mem_n1", 32'(mem_st.valid), 32'd0);
      tick(1);
      checkOutput("a_mem_n2", 32'(mem_st.valid), 32'd1);
      checkOutput("a_mem_data", mem_st.data, 32'h11);
      checkOutput("a_cpl_n2", 32'(cpl_st.valid), 32'd0);
      tick(1);
      checkOutput("a_cpl_n3", 32'(cpl_st.valid), 32'd1);
      checkOutput("a_cpl_data", cpl_st.data, 32'h22);
      checkOutput("a_mem_n3", 32'(mem_st.valid), 32'd0);
      waitDrain("a");

      // Classification boundaries, multi-beat packets, skipped channel
      doReset();
      applyStimulus(mk(1, 1, 8'h0A, 32'd1), '0, 1'b0);
      applyStimulus(mk(1, 1, 8'h4B, 32'd2), '0, 1'b0);
      applyStimulus(mk(1, 0, 8'h4A, 32'd3), mk(0, 0, 8'h00, 32'd4), 1'b0);
      applyStimulus(mk(0, 1, 8'h00, 32'd5), '0, 1'b0);
      applyStimulus(mk(1, 0, 8'h4A, 32'd6), mk(0, 1, 8'h00, 32'd7), 1'b0);
      applyStimulus('0, mk(1, 1, 8'h00, 32'd8), 1'b0);
      waitDrain("b");
      checkOutput("b_cpl_beats", 32'(cpl_beats), 32'd6);
      checkOutput("b_mem_beats", 32'(mem_beats), 32'd2);
      checkOutput("b_err", 32'(err), 32'd0);
`ifdef PKT_RX_STATS_EN
      checkOutput("b_cpl_cnt", cpl_cnt, 32'd3);
      checkOutput("b_mem_cnt", mem_cnt, 32'd2);
`endif

      // Memory sink stalled must not block completions
      doReset();
      mem_ready = 1'b0;
      applyStimulus(mk(1, 1, 8'h00, 32'h31), '0, 1'b0);
      applyStimulus(mk(1, 1, 8'h4A, 32'h32), '0, 1'b0);
      tick(4);
      checkOutput("c_cpl_passed", 32'(cpl_q.size()), 32'd0);
      checkOutput("c_cpl_beats", 32'(cpl_beats), 32'd1);
      checkOutput("c_mem_held", 32'(mem_st.valid), 32'd1);
      checkOutput("c_mem_data", mem_st.data, 32'h31);
      tick(3);
      checkOutput("c_mem_stable", mem_st.data, 32'h31);
      mem_ready = 1'b1;
      tick(2);
      checkOutput("c_mem_sent", 32'(mem_q.size()), 32'd0);
      checkOutput("c_mem_cleared", 32'(mem_st.valid), 32'd0);

      // Both sinks stalled, 2 beats per cycle: ready drops at usedw 10
      doReset();
      cpl_ready = 1'b0;
      mem_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(mk(1, 0, 8'h00, 32'(2 * i)), mk(0, 1, 8'h00, 32'(2 * i + 1)), 1'b0);
         if (i < 6) checkOutput($sformatf("d_ready_%0d", i), 32'(tx_ready), (i < 5) ? 32'd1 : 32'd0);
      end
      checkOutput("d_ready_full", 32'(tx_ready), 32'd0);
      checkOutput("d_err", 32'(err), 32'd0);
      waitDrain("d");
      checkOutput("d_mem_beats", 32'(mem_beats), 32'd18);

      // Overrun: the tenth cycle does not fit and is dropped whole
      doReset();
      cpl_ready = 1'b0;
      mem_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(mk(1, 0, 8'h4A, 32'(64 + 2 * i)), mk(0, 1, 8'h00, 32'(65 + 2 * i)), i == 9);
      end
      checkOutput("e_err_ovf", 32'(err), 32'd1);
      waitDrain("e");
      checkOutput("e_cpl_beats", 32'(cpl_beats), 32'd18);
      checkOutput("e_err_sticky", 32'(err), 32'(m_err));
      doReset();
      checkOutput("e_err_cleared", 32'(err), 32'd0);

      // eop-only beat with no open packet
      applyStimulus(mk(0, 1, 8'h00, 32'h41), '0, 1'b0);
      tick(4);
      checkOutput("f_err_orphan", 32'(err), 32'd2);
      applyStimulus(mk(1, 1, 8'h4A, 32'h42), '0, 1'b0);
      waitDrain("f");
      checkOutput("f_err_model", 32'(err), 32'(m_err));
      checkOutput("f_cpl_beats", 32'(cpl_beats), 32'd1);
      checkOutput("f_mem_beats", 32'(mem_beats), 32'd0);

      // Reset in the middle of a 4-beat packet
      doReset();
      applyStimulus(mk(1, 0, 8'h00, 32'h51), '0, 1'b0);
      applyStimulus(mk(0, 0, 8'h00, 32'h52), '0, 1'b0);
      rst = 1'b1;
      tick(1);
      checkOutput("g_cpl_invalid", 32'(cpl_st.valid), 32'd0);
      checkOutput("g_mem_invalid", 32'(mem_st.valid), 32'd0);
      tick(1);
      modelReset();
      rst = 1'b0;
      checkOutput("g_ready_after_rst", 32'(tx_ready), 32'd1);
`ifdef PKT_RX_STATS_EN
      checkOutput("g_cpl_cnt0", cpl_cnt, 32'd0);
      checkOutput("g_mem_cnt0", mem_cnt, 32'd0);
`endif
      applyStimulus(mk(1, 0, 8'h4A, 32'h61), '0, 1'b0);
      applyStimulus(mk(0, 0, 8'h00, 32'h62), '0, 1'b0);
      applyStimulus(mk(0, 0, 8'h00, 32'h63), '0, 1'b0);
      applyStimulus(mk(0, 1, 8'h00, 32'h64), '0, 1'b0);
      waitDrain("g");
      checkOutput("g_cpl_beats", 32'(cpl_beats), 32'd4);
      checkOutput("g_mem_beats", 32'(mem_beats), 32'd0);
`ifdef PKT_RX_STATS_EN
      checkOutput("g_cpl_cnt1", cpl_cnt, 32'd1);
      checkOutput("g_mem_cnt1", mem_cnt, 32'd0);
      checkOutput("g_cpl_cnt_model", cpl_cnt, 32'(m_cpl_pkts));
`endif

      // Mixed traffic with toggling sink readies, upstream honouring ready
      doReset();
      for (int i = 0; i < 80; i++) begin
         cpl_ready = ($urandom_range(0, 1) != 0);
         mem_ready = ($urandom_range(0, 3) != 0);
         b0 = '0;
         b1 = '0;
         if (tx_ready) begin
            if ($urandom_range(0, 3) != 0) nextBeat(b0);
            if ($urandom_range(0, 1) != 0) nextBeat(b1);
         end
         applyStimulus(b0, b1, 1'b0);
      end
      while (g_left != 0) begin
         nextBeat(b0);
         applyStimulus(b0, '0, 1'b0);
      end
      waitDrain("h");
      checkOutput("h_err", 32'(err), 32'(m_err));
`ifdef PKT_RX_STATS_EN
      checkOutput("h_cpl_cnt", cpl_cnt, 32'(m_cpl_pkts));
      checkOutput("h_mem_cnt", mem_cnt, 32'(m_mem_pkts));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
